// File: rtl/otp_pkg.sv
// Shared constants and helpers for the one-time-pad cipher engine.
package otp_pkg;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Maximal-length Galois (right-shift) tap masks; 8-bit is x^8+x^6+x^5+x^4+1.
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        case (width)
            16:      return 32'h0000_B400;
            32:      return 32'h8020_0003;
            default: return 32'h0000_00B8;
        endcase
    endfunction

endpackage

// File: rtl/otp_cipher_engine_lfsr.sv
// Galois LFSR pad generator; advances only when step is asserted.
module otp_lfsr
    import otp_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter logic [W-1:0] SEED = {{(W-1){1'b0}}, 1'b1}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    output logic [W-1:0] state
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    logic [W-1:0] state_q;
    logic [W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (step) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/otp_cipher_engine.sv
// One-time-pad engine: encrypt stores a fresh LFSR pad in a slot, decrypt consumes it once.
module otp_cipher_engine
    import otp_pkg::*;
#(
    parameter int unsigned DATA_W            = 8,
    parameter int unsigned DEPTH             = 8,
    parameter logic [DATA_W-1:0] LFSR_SEED   = {{(DATA_W-1){1'b0}}, 1'b1},
    parameter int unsigned IDX_W             = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              zeroize,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_err,
    output logic [IDX_W:0]    pad_avail
);

    localparam int unsigned CNT_W = IDX_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  pad_avail_q, pad_avail_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              out_err_q, out_err_d;

    logic              full_c;
    logic              enc_acc_c;
    logic              dec_acc_c;
    logic [DATA_W-1:0] pad_c;

    // First empty slot after 'from', wrapping; stays at 'from' when none is free.
    function automatic logic [IDX_W-1:0] next_free(input logic [DEPTH-1:0] v,
                                                   input logic [IDX_W-1:0] from);
        logic [IDX_W-1:0] cand;
        logic             found;
        next_free = from;
        found     = 1'b0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            cand = from + IDX_W'(i);
            if (!found && !v[cand]) begin
                next_free = cand;
                found     = 1'b1;
            end
        end
    endfunction

    assign full_c    = (pad_avail_q == CNT_W'(DEPTH));
    assign in_ready  = en & ~zeroize & (~out_valid_q | out_ready)
                     & ~((in_mode == MODE_ENC) & full_c);
    assign enc_acc_c = in_valid & in_ready & (in_mode == MODE_ENC);
    assign dec_acc_c = in_valid & in_ready & (in_mode == MODE_DEC);

    otp_lfsr #(
        .W    (DATA_W),
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (enc_acc_c),
        .state (pad_c)
    );

    always_comb begin
        mem_d       = mem_q;
        valid_d     = valid_q;
        wr_ptr_d    = wr_ptr_q;
        pad_avail_d = pad_avail_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_err_d   = out_err_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (zeroize) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            valid_d     = '0;
            wr_ptr_d    = '0;
            pad_avail_d = '0;
        end else if (enc_acc_c) begin
            mem_d[wr_ptr_q]   = pad_c;
            valid_d[wr_ptr_q] = 1'b1;
            pad_avail_d       = pad_avail_q + CNT_W'(1);
            wr_ptr_d          = next_free(valid_d, wr_ptr_q);
            out_valid_d       = 1'b1;
            out_data_d        = in_data ^ pad_c;
            out_idx_d         = wr_ptr_q;
            out_err_d         = 1'b0;
        end else if (dec_acc_c) begin
            out_valid_d = 1'b1;
            out_idx_d   = in_idx;
            if (valid_q[in_idx]) begin
                out_data_d      = mem_q[in_idx] ^ in_data;
                out_err_d       = 1'b0;
                valid_d[in_idx] = 1'b0;
                mem_d[in_idx]   = '0;
                pad_avail_d     = pad_avail_q - CNT_W'(1);
                // A full store left wr_ptr parked; the freed slot is now the only hole.
                if (full_c) begin
                    wr_ptr_d = in_idx;
                end
            end else begin
                out_data_d = '0;
                out_err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            valid_q     <= '0;
            wr_ptr_q    <= '0;
            pad_avail_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            valid_q     <= valid_d;
            wr_ptr_q    <= wr_ptr_d;
            pad_avail_q <= pad_avail_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_err   = out_err_q;
    assign pad_avail = pad_avail_q;

endmodule

// File: tb/tb_otp_cipher_engine.sv
// Directed vector bench for otp_cipher_engine (DATA_W=8, DEPTH=8, seed 1).
module tb_otp_cipher_engine;

    localparam int unsigned DW = 8;
    localparam int unsigned IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          zeroize;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [DW-1:0] in_data;
    logic [IW-1:0] in_idx;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          out_err;
    logic [IW:0]   pad_avail;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    otp_cipher_engine #(
        .DATA_W    (8),
        .DEPTH     (8),
        .LFSR_SEED (8'h01)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .zeroize   (zeroize),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .in_idx    (in_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_err   (out_err),
        .pad_avail (pad_avail)
    );

    typedef struct {
        logic       zz;
        logic       mode;
        logic [7:0] data;
        logic [2:0] idx;
        logic [7:0] e_data;
        logic [2:0] e_idx;
        logic       e_err;
        logic [3:0] e_avail;
    } vec_t;

    vec_t tv[14];

    function automatic vec_t mk(logic zz, logic mode, logic [7:0] data, logic [2:0] idx,
                                logic [7:0] e_data, logic [2:0] e_idx, logic e_err,
                                logic [3:0] e_avail);
        vec_t v;
        v.zz = zz; v.mode = mode; v.data = data; v.idx = idx;
        v.e_data = e_data; v.e_idx = e_idx; v.e_err = e_err; v.e_avail = e_avail;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int i);
        if (tv[i].zz) begin
            in_valid = 1'b0;
            zeroize  = 1'b1;
            tick();
            zeroize  = 1'b0;
            chk($sformatf("v%0d_zeroize_avail", i), 32'(pad_avail), 32'd0);
        end
        in_valid = 1'b1;
        in_mode  = tv[i].mode;
        in_data  = tv[i].data;
        in_idx   = tv[i].idx;
        tick();
        in_valid = 1'b0;
        chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d_data", i),  32'(out_data),  32'(tv[i].e_data));
        chk($sformatf("v%0d_idx", i),   32'(out_idx),   32'(tv[i].e_idx));
        chk($sformatf("v%0d_err", i),   32'(out_err),   32'(tv[i].e_err));
        chk($sformatf("v%0d_avail", i), 32'(pad_avail), 32'(tv[i].e_avail));
    endtask

    task automatic op(input string name, input logic mode, input logic [7:0] data,
                      input logic [2:0] idx, input logic [7:0] e_data, input logic [2:0] e_idx,
                      input logic e_err, input logic [3:0] e_avail);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        in_idx   = idx;
        tick();
        in_valid = 1'b0;
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_data"},  32'(out_data),  32'(e_data));
        chk({name, "_idx"},   32'(out_idx),   32'(e_idx));
        chk({name, "_err"},   32'(out_err),   32'(e_err));
        chk({name, "_avail"}, 32'(pad_avail), 32'(e_avail));
    endtask

    logic [7:0] zpads [4];

    initial begin
        // Pad sequence from seed 1: 01 B8 5C 2E 17 B3 E1 C8 64 32 19 B4 5A 2D AE 57 93 F1
        tv[0]  = mk(0, 0, 8'h41, 0, 8'h40, 0, 0, 1);
        tv[1]  = mk(0, 1, 8'h40, 0, 8'h41, 0, 0, 0);
        tv[2]  = mk(0, 1, 8'h40, 0, 8'h00, 0, 1, 0);
        tv[3]  = mk(1, 0, 8'h10, 0, 8'hA8, 0, 0, 1);
        tv[4]  = mk(0, 0, 8'h11, 0, 8'h4D, 1, 0, 2);
        tv[5]  = mk(0, 0, 8'h12, 0, 8'h3C, 2, 0, 3);
        tv[6]  = mk(0, 0, 8'h13, 0, 8'h04, 3, 0, 4);
        tv[7]  = mk(0, 0, 8'h14, 0, 8'hA7, 4, 0, 5);
        tv[8]  = mk(0, 0, 8'h15, 0, 8'hF4, 5, 0, 6);
        tv[9]  = mk(0, 0, 8'h16, 0, 8'hDE, 6, 0, 7);
        tv[10] = mk(0, 0, 8'h17, 0, 8'h73, 7, 0, 8);
        tv[11] = mk(0, 1, 8'h04, 3, 8'h13, 3, 0, 7);
        tv[12] = mk(0, 0, 8'h00, 0, 8'h32, 3, 0, 8);
        tv[13] = mk(0, 1, 8'hDE, 6, 8'h16, 6, 0, 7);
        zpads[0] = 8'h5A; zpads[1] = 8'h2D; zpads[2] = 8'hAE; zpads[3] = 8'h57;

        rst = 1'b1; en = 1'b1; zeroize = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
        in_data = '0; in_idx = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_avail",     32'(pad_avail), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        for (int i = 0; i <= 10; i++) apply(i);

        // Store full: encrypts back-pressured, decrypts still accepted.
        in_mode = 1'b0; #1;
        chk("full_ready_enc", 32'(in_ready), 32'd0);
        in_mode = 1'b1; #1;
        chk("full_ready_dec", 32'(in_ready), 32'd1);
        in_mode = 1'b0;
        tick();

        for (int i = 11; i <= 13; i++) apply(i);

        // Output stall with a held decrypt request.
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        op("stall_enc", 0, 8'h55, 0, 8'h4C, 6, 0, 8);
        in_valid = 1'b1; in_mode = 1'b1; in_idx = 3'd0; in_data = 8'h00;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_ready", k), 32'(in_ready), 32'd0);
            tick();
            chk($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_data", k),  32'(out_data),  32'h4C);
            chk($sformatf("stall%0d_avail", k), 32'(pad_avail), 32'd8);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("unstall_dec_data",  32'(out_data),  32'hB8);
        chk("unstall_dec_avail", 32'(pad_avail), 32'd7);
        op("post_stall_enc", 0, 8'h00, 0, 8'hB4, 0, 0, 8);

        // Zeroize after four encrypts, with a pending beat held across it.
        zeroize = 1'b1; tick(); zeroize = 1'b0;
        chk("z0_avail", 32'(pad_avail), 32'd0);
        for (int i = 0; i < 4; i++)
            op($sformatf("zenc%0d", i), 0, 8'h00, 0, zpads[i], 3'(i), 0, 4'(i + 1));
        out_ready = 1'b0;
        zeroize = 1'b1; tick(); zeroize = 1'b0;
        chk("z1_avail",      32'(pad_avail), 32'd0);
        chk("z1_keep_valid", 32'(out_valid), 32'd1);
        chk("z1_keep_data",  32'(out_data),  32'h57);
        out_ready = 1'b1;
        op("z_dec", 1, 8'h00, 2, 8'h00, 2, 1, 0);
        op("z_enc", 0, 8'h00, 0, 8'h93, 0, 0, 1);

        // Enable low: nothing accepted, pending beat still drains.
        en = 1'b0; in_valid = 1'b1; in_mode = 1'b0; #1;
        chk("en_lo_ready", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("en_lo_valid", 32'(out_valid), 32'd0);
        chk("en_lo_avail", 32'(pad_avail), 32'd1);
        en = 1'b1;

        // Reset mid-stream drops the beat and reseeds the LFSR.
        out_ready = 1'b0;
        op("pre_rst_enc", 0, 8'h00, 0, 8'hF1, 1, 0, 2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_avail", 32'(pad_avail), 32'd0);
        @(negedge clk) rst = 1'b0;
        out_ready = 1'b1;
        tick();
        op("post_rst_enc", 0, 8'h41, 0, 8'h40, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
